rc5_key_expand: RTL and testbench
=================================

Name: rc5_key_expand

Overview:
Upstream neighbour of the RC5 decipher stage. Runs the RC5 key schedule: initialises the subkey table S[0..T-1] from magic constants P/Q, mixes in the secret key, then serves S to the decipher through two read ports.
The decipher drives its subkey addresses into this block and receives S[addr1]/S[addr2] back. The decipher must not start until oReady is high.

Parameters:
W, 32, word width in bits; legal values 16/32/64; selects P/Q.
R, 12, number of rounds.
B, 16, key length in bytes; minimum 1.
T, 2*(R+1), number of subkey words (derived).
T_LENGTH, $clog2(T), subkey address width (derived).
U, W/8, bytes per word (derived).
C, max(1, ceil(B/U)), number of key words L (derived).
N, 3*max(T,C), number of mix iterations (derived).

Ports:
clk  in  1  single clock, rising edge.
rst  in  1  asynchronous, active-low reset.
iStart  in  1  one-cycle start pulse; sampled only in IDLE or DONE.
iKey  in  8*B  secret key; byte k sits at bits [8k+7:8k]; must be held stable from iStart until oReady.
iS_address1  in  T_LENGTH  read address, port 1.
iS_address2  in  T_LENGTH  read address, port 2.
oS_sub_i1  out  W  S[iS_address1], registered.
oS_sub_i2  out  W  S[iS_address2], registered.
oBusy  out  1  high during INIT_S, LOAD_L and MIX.
oReady  out  1  high in DONE; S table is valid.

Behaviour:
- Reset (rst=0, async): state=IDLE; S[], L[], A, B, i, j, iteration counter all 0; oS_sub_i1=oS_sub_i2=0; oBusy=0; oReady=0.
- Magic constants:
  - W=16: P=B7E1, Q=9E37.
  - W=32: P=B7E15163, Q=9E3779B9.
  - W=64: P=B7E151628AED2A6B, Q=9E3779B97F4A7C15.
- States and transitions:
  - IDLE: on iStart -> INIT_S with index=0.
  - INIT_S: one word per cycle; S[0]=P, S[k]=S[k-1]+Q mod 2^W. After S[T-1] is written -> LOAD_L.
  - LOAD_L: 1 cycle. L[m] = key bytes m*U..m*U+U-1, little-endian (lowest byte in LSBs). Bytes beyond B are 0. Clear A, B, i, j and the iteration counter -> MIX_A.
  - MIX_A: A = S[i] = (S[i]+A+B) <<< 3 -> MIX_B.
  - MIX_B: B = L[j] = (L[j]+A+B) <<< ((A+B) mod W), using the new A and the low log2(W) bits of the rotate amount. Then i=(i+1) mod T, j=(j+1) mod C, counter++. If counter reaches N -> DONE, else -> MIX_A.
  - DONE: oReady=1. iStart restarts at INIT_S with oReady cleared on the same edge.
- Arithmetic: all additions mod 2^W; rotate is a left barrel rotate.
- Latency: oReady rises T+1+2N clock edges after the edge that samples iStart (defaults: 26+1+156 = 183).
- Read ports: registered, one-cycle latency, valid in every state. Reads during mixing return in-progress values and are legal but meaningless.
- Same-address read on both ports: both outputs return the same word.
- iStart while busy: ignored.
- Reset mid-operation: immediate return to IDLE with the reset values above.

Optional Feature:
RC5_S_WRITE_EN:
- When defined, adds three ports: iS_we (1), iS_waddr (T_LENGTH), iS_wdata (W).
- In IDLE or DONE, iS_we=1 writes iS_wdata into S[iS_waddr] on the clock edge. Precomputed subkeys can then be loaded directly; any such write forces oReady=1.
- Writes in other states are ignored.
- A write and a read to the same address in the same cycle return the old value.
- When not defined, the ports do not exist and S is written only by the key schedule.

Test Plan:
- Reset, then check all outputs: oReady=0, oBusy=0, oS_sub_i1=oS_sub_i2=0; addr 0/1 read back 0.
- W=32, key=all zero, iStart pulse -> oBusy high on the next cycle; oReady high exactly 183 edges after the start edge; all 26 words of S match a C reference model.
- Same key, schedule output driving the RC5 decipher with A=EEDBA521, B=6D8F4B15 (ciphertext 21A5DBEE154B8F6D, little-endian) -> plaintext A=0, B=0.
- Assert iStart at cycle 50 of a run -> ignored; oReady still rises at 183. Pulse rst low at cycle 100 -> IDLE and S cleared immediately.
- B=5 (C=2, key bytes 01..05) -> L[1] = 0x00000005; S matches the model; this checks C wrap and zero padding.
- RC5_S_WRITE_EN: in IDLE write S[25]=DEADBEEF -> oReady=1; next-cycle read of addr 25 returns DEADBEEF; the same write during MIX has no effect.

Source files
------------

// File: rtl/rc5_key_expand.sv
// RC5 key schedule: P/Q table init, key load, 3*max(T,C) mixing passes, and two registered S read ports.
// Optional macro RC5_S_WRITE_EN adds a direct S write port, usable in IDLE/DONE only.
module rc5_key_expand #(
  parameter  int W        = 32,
  parameter  int R        = 12,
  parameter  int B        = 16,
  localparam int T        = 2 * (R + 1),
  localparam int T_LENGTH = $clog2(T),
  localparam int U        = W / 8,
  localparam int C        = (B + U - 1) / U,
  localparam int N        = 3 * ((T > C) ? T : C)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                iStart,
  input  logic [8*B-1:0]      iKey,
  input  logic [T_LENGTH-1:0] iS_address1,
  input  logic [T_LENGTH-1:0] iS_address2,
`ifdef RC5_S_WRITE_EN
  input  logic                iS_we,
  input  logic [T_LENGTH-1:0] iS_waddr,
  input  logic [W-1:0]        iS_wdata,
`endif
  output logic [W-1:0]        oS_sub_i1,
  output logic [W-1:0]        oS_sub_i2,
  output logic                oBusy,
  output logic                oReady
);

  localparam int LOGW = $clog2(W);
  localparam int JW   = (C > 1) ? $clog2(C) : 1;
  localparam int CW   = $clog2(N + 1);

  localparam logic [63:0] P_ALL = (W == 16) ? 64'h000000000000B7E1 :
                                  (W == 32) ? 64'h00000000B7E15163 : 64'hB7E151628AED2A6B;
  localparam logic [63:0] Q_ALL = (W == 16) ? 64'h0000000000009E37 :
                                  (W == 32) ? 64'h000000009E3779B9 : 64'h9E3779B97F4A7C15;
  localparam logic [W-1:0] P = P_ALL[W-1:0];
  localparam logic [W-1:0] Q = Q_ALL[W-1:0];

  localparam logic [T_LENGTH-1:0] I_LAST   = T_LENGTH'(T - 1);
  localparam logic [JW-1:0]       J_LAST   = JW'(C - 1);
  localparam logic [CW-1:0]       CNT_LAST = CW'(N - 1);
  localparam logic [T_LENGTH:0]   T_WORDS  = (T_LENGTH + 1)'(T);

  typedef enum logic [2:0] {IDLE, INIT_S, LOAD_L, MIX_A, MIX_B, DONE} state_t;

  state_t                state_q, state_d;
  logic [W-1:0]          s_q [T];
  logic [W-1:0]          s_d [T];
  logic [W-1:0]          l_q [C];
  logic [W-1:0]          l_d [C];
  logic [W-1:0]          a_q, a_d, b_q, b_d;
  logic [T_LENGTH-1:0]   i_q, i_d;
  logic [JW-1:0]         j_q, j_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [W-1:0]          rd1_q, rd1_d, rd2_q, rd2_d;
  logic [W*C-1:0]        key_pad;
  logic [W-1:0]          mix_a, mix_b, ab_sum;

  function automatic logic [W-1:0] rotl(input logic [W-1:0] x, input logic [LOGW-1:0] sh);
    logic [2*W-1:0] dbl;
    dbl = {x, x} << sh;
    return dbl[2*W-1:W];
  endfunction

  // Non-power-of-two T leaves unused addresses; those read as zero and are never written.
  function automatic logic in_range(input logic [T_LENGTH-1:0] addr);
    return {1'b0, addr} < T_WORDS;
  endfunction

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    l_d     = l_q;
    a_d     = a_q;
    b_d     = b_q;
    i_d     = i_q;
    j_d     = j_q;
    cnt_d   = cnt_q;
    key_pad = '0;
    key_pad[8*B-1:0] = iKey;
    ab_sum  = a_q + b_q;
    mix_a   = rotl(s_q[i_q] + a_q + b_q, LOGW'(3));
    mix_b   = rotl(l_q[j_q] + ab_sum, ab_sum[LOGW-1:0]);
    rd1_d   = in_range(iS_address1) ? s_q[iS_address1] : '0;
    rd2_d   = in_range(iS_address2) ? s_q[iS_address2] : '0;

    case (state_q)
      IDLE, DONE: begin
        // a_q doubles as the running P + k*Q accumulator during INIT_S.
        if (iStart) begin
          state_d = INIT_S;
          i_d     = '0;
          a_d     = P;
        end
`ifdef RC5_S_WRITE_EN
        else if (iS_we && in_range(iS_waddr)) begin
          s_d[iS_waddr] = iS_wdata;
          state_d       = DONE;
        end
`endif
      end
      INIT_S: begin
        s_d[i_q] = a_q;
        a_d      = a_q + Q;
        if (i_q == I_LAST) begin
          state_d = LOAD_L;
          i_d     = '0;
        end else begin
          i_d = i_q + T_LENGTH'(1);
        end
      end
      LOAD_L: begin
        for (int m = 0; m < C; m++) l_d[m] = key_pad[m*W +: W];
        a_d     = '0;
        b_d     = '0;
        i_d     = '0;
        j_d     = '0;
        cnt_d   = '0;
        state_d = MIX_A;
      end
      MIX_A: begin
        s_d[i_q] = mix_a;
        a_d      = mix_a;
        state_d  = MIX_B;
      end
      MIX_B: begin
        l_d[j_q] = mix_b;
        b_d      = mix_b;
        i_d      = (i_q == I_LAST) ? '0 : i_q + T_LENGTH'(1);
        j_d      = (j_q == J_LAST) ? '0 : j_q + JW'(1);
        cnt_d    = cnt_q + CW'(1);
        state_d  = (cnt_q == CNT_LAST) ? DONE : MIX_A;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      s_q     <= '{default: '0};
      l_q     <= '{default: '0};
      a_q     <= '0;
      b_q     <= '0;
      i_q     <= '0;
      j_q     <= '0;
      cnt_q   <= '0;
      rd1_q   <= '0;
      rd2_q   <= '0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      l_q     <= l_d;
      a_q     <= a_d;
      b_q     <= b_d;
      i_q     <= i_d;
      j_q     <= j_d;
      cnt_q   <= cnt_d;
      rd1_q   <= rd1_d;
      rd2_q   <= rd2_d;
    end
  end

  assign oS_sub_i1 = rd1_q;
  assign oS_sub_i2 = rd2_q;
  assign oBusy     = (state_q == INIT_S) || (state_q == LOAD_L) ||
                     (state_q == MIX_A)  || (state_q == MIX_B);
  assign oReady    = (state_q == DONE);

endmodule

// File: tb/tb_rc5_key_expand.sv
// Directed bench for rc5_key_expand (W=32, R=12): B=16 and B=5 instances, reference key schedule,
// RC5 known-answer decipher, latency, start/reset corner cases, and the RC5_S_WRITE_EN port when defined.
module tb_rc5_key_expand;
  localparam int T  = 26;
  localparam int TL = 5;
  localparam int R  = 12;

  logic          clk = 1'b0;
  logic          rst;
  logic          start, start5;
  logic [127:0]  key;
  logic [39:0]   key5;
  logic [TL-1:0] a1, a2, a1_5, a2_5;
  logic [31:0]   q1, q2, q1_5, q2_5;
  logic          busy, ready, busy5, ready5;
`ifdef RC5_S_WRITE_EN
  logic          we, we5;
  logic [TL-1:0] waddr, waddr5;
  logic [31:0]   wdata, wdata5;
`endif

  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_s [T];
  logic [31:0] got_s [T];

  always #5 clk = ~clk;

  rc5_key_expand #(.W(32), .R(12), .B(16)) dut (
    .clk(clk), .rst(rst), .iStart(start), .iKey(key),
    .iS_address1(a1), .iS_address2(a2),
`ifdef RC5_S_WRITE_EN
    .iS_we(we), .iS_waddr(waddr), .iS_wdata(wdata),
`endif
    .oS_sub_i1(q1), .oS_sub_i2(q2), .oBusy(busy), .oReady(ready)
  );

  rc5_key_expand #(.W(32), .R(12), .B(5)) dut5 (
    .clk(clk), .rst(rst), .iStart(start5), .iKey(key5),
    .iS_address1(a1_5), .iS_address2(a2_5),
`ifdef RC5_S_WRITE_EN
    .iS_we(we5), .iS_waddr(waddr5), .iS_wdata(wdata5),
`endif
    .oS_sub_i1(q1_5), .oS_sub_i2(q2_5), .oBusy(busy5), .oReady(ready5)
  );

  function automatic logic [31:0] rotl(input logic [31:0] x, input logic [31:0] s);
    int sh;
    sh = int'(s & 32'd31);
    if (sh == 0) return x;
    return (x << sh) | (x >> (32 - sh));
  endfunction

  function automatic logic [31:0] rotr(input logic [31:0] x, input logic [31:0] s);
    return rotl(x, 32'd32 - (s & 32'd31));
  endfunction

  // Straight transcription of the RC5 reference key schedule into exp_s.
  task automatic model_schedule(input logic [127:0] k, input int nb);
    logic [31:0] l [4];
    logic [31:0] a, b;
    int c, n, ii, jj;
    c = (nb + 3) / 4;
    if (c < 1) c = 1;
    for (int m = 0; m < 4; m++) l[m] = 32'h0;
    for (int x = nb - 1; x >= 0; x--) l[x/4] = (l[x/4] << 8) + {24'h0, k[8*x +: 8]};
    exp_s[0] = 32'hB7E15163;
    for (int x = 1; x < T; x++) exp_s[x] = exp_s[x-1] + 32'h9E3779B9;
    a = 0; b = 0; ii = 0; jj = 0;
    n = 3 * ((T > c) ? T : c);
    for (int x = 0; x < n; x++) begin
      exp_s[ii] = rotl(exp_s[ii] + a + b, 32'd3);
      a = exp_s[ii];
      l[jj] = rotl(l[jj] + a + b, a + b);
      b = l[jj];
      ii = (ii + 1) % T;
      jj = (jj + 1) % c;
    end
  endtask

  task automatic read_all(input bit which);
    for (int k = 0; k < T; k += 2) begin
      if (which) begin a1_5 = TL'(k); a2_5 = TL'(k + 1); end
      else       begin a1   = TL'(k); a2   = TL'(k + 1); end
      @(posedge clk); #1;
      got_s[k]     = which ? q1_5 : q1;
      got_s[k + 1] = which ? q2_5 : q2;
    end
  endtask

  task automatic test_reset;
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (q1 !== 32'h0) begin errors++; $display("FAIL reset_q1: got %h want 0", q1); end
    checks++; if (q2 !== 32'h0) begin errors++; $display("FAIL reset_q2: got %h want 0", q2); end
    rst = 1'b1;
    a1 = 0; a2 = 1;
    @(posedge clk); #1;
    checks++; if (q1 !== 32'h0) begin errors++; $display("FAIL reset_read_addr0: got %h want 0", q1); end
    checks++; if (q2 !== 32'h0) begin errors++; $display("FAIL reset_read_addr1: got %h want 0", q2); end
    $display("test_reset done");
  endtask

  task automatic test_zero_key;
    int edges;
    logic [31:0] pa, pb;
    key = '0;
    model_schedule(key, 16);
    start = 1'b1; @(posedge clk); #1; start = 1'b0;
    checks++;
    if (busy !== 1'b1 || ready !== 1'b0) begin
      errors++; $display("FAIL zero_key_busy: busy=%b ready=%b want busy=1 ready=0", busy, ready);
    end
    edges = 0;
    for (int e = 1; e <= 400; e++) begin
      @(posedge clk); #1;
      if (ready === 1'b1) begin edges = e; break; end
    end
    checks++; if (edges !== 183) begin errors++; $display("FAIL zero_key_latency: got %0d edges want 183", edges); end
    read_all(0);
    for (int k = 0; k < T; k++) begin
      checks++;
      if (got_s[k] !== exp_s[k]) begin errors++; $display("FAIL zero_key_S%0d: got %h want %h", k, got_s[k], exp_s[k]); end
    end
    pa = 32'hEEDBA521; pb = 32'h6D8F4B15;
    for (int r = R; r >= 1; r--) begin
      pb = rotr(pb - got_s[2*r + 1], pa) ^ pa;
      pa = rotr(pa - got_s[2*r], pb) ^ pb;
    end
    pb = pb - got_s[1];
    pa = pa - got_s[0];
    checks++; if (pa !== 32'h0) begin errors++; $display("FAIL decipher_A: got %h want 00000000", pa); end
    checks++; if (pb !== 32'h0) begin errors++; $display("FAIL decipher_B: got %h want 00000000", pb); end
    $display("test_zero_key done");
  endtask

  task automatic test_restart_from_done;
    int edges;
    start = 1'b1; @(posedge clk); #1; start = 1'b0;
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL restart_ready_clear: got %b want 0", ready); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL restart_busy: got %b want 1", busy); end
    edges = 0;
    for (int e = 1; e <= 400; e++) begin
      @(posedge clk); #1;
      if (ready === 1'b1) begin edges = e; break; end
    end
    checks++; if (edges !== 183) begin errors++; $display("FAIL restart_latency: got %0d edges want 183", edges); end
    $display("test_restart_from_done done");
  endtask

  task automatic test_start_while_busy;
    int edges;
    start = 1'b1; @(posedge clk); #1; start = 1'b0;
    edges = 0;
    for (int e = 1; e <= 400; e++) begin
      @(posedge clk); #1;
      if (e == 49) start = 1'b1;
      if (e == 50) start = 1'b0;
      if (ready === 1'b1) begin edges = e; break; end
    end
    checks++; if (edges !== 183) begin errors++; $display("FAIL busy_start_latency: got %0d edges want 183", edges); end
    read_all(0);
    for (int k = 0; k < T; k++) begin
      checks++;
      if (got_s[k] !== exp_s[k]) begin errors++; $display("FAIL busy_start_S%0d: got %h want %h", k, got_s[k], exp_s[k]); end
    end
    $display("test_start_while_busy done");
  endtask

  task automatic test_reset_mid_run;
    start = 1'b1; @(posedge clk); #1; start = 1'b0;
    repeat (99) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %b want 0", busy); end
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL midreset_ready: got %b want 0", ready); end
    checks++; if (q1 !== 32'h0) begin errors++; $display("FAIL midreset_q1: got %h want 0", q1); end
    checks++; if (q2 !== 32'h0) begin errors++; $display("FAIL midreset_q2: got %h want 0", q2); end
    #1 rst = 1'b1;
    @(posedge clk); #1;
    read_all(0);
    for (int k = 0; k < T; k++) begin
      checks++;
      if (got_s[k] !== 32'h0) begin errors++; $display("FAIL midreset_S%0d: got %h want 00000000", k, got_s[k]); end
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midreset_idle: busy=%b want 0", busy); end
    $display("test_reset_mid_run done");
  endtask

  task automatic test_short_key;
    int edges;
    model_schedule({88'h0, key5}, 5);
    start5 = 1'b1; @(posedge clk); #1; start5 = 1'b0;
    edges = 0;
    for (int e = 1; e <= 400; e++) begin
      @(posedge clk); #1;
      if (ready5 === 1'b1) begin edges = e; break; end
    end
    checks++; if (edges !== 183) begin errors++; $display("FAIL short_key_latency: got %0d edges want 183", edges); end
    read_all(1);
    for (int k = 0; k < T; k++) begin
      checks++;
      if (got_s[k] !== exp_s[k]) begin errors++; $display("FAIL short_key_S%0d: got %h want %h", k, got_s[k], exp_s[k]); end
    end
    $display("test_short_key done");
  endtask

`ifdef RC5_S_WRITE_EN
  task automatic test_s_write;
    int edges;
    a1 = 25;
    we = 1'b1; waddr = 25; wdata = 32'hDEADBEEF;
    @(posedge clk); #1;
    we = 1'b0;
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL write_ready: got %b want 1", ready); end
    checks++; if (q1 !== 32'h0) begin errors++; $display("FAIL write_read_old: got %h want 00000000", q1); end
    @(posedge clk); #1;
    checks++; if (q1 !== 32'hDEADBEEF) begin errors++; $display("FAIL write_readback: got %h want deadbeef", q1); end
    key = '0;
    model_schedule(key, 16);
    start = 1'b1; @(posedge clk); #1; start = 1'b0;
    edges = 0;
    for (int e = 1; e <= 400; e++) begin
      @(posedge clk); #1;
      if (e == 59) begin we = 1'b1; waddr = 25; wdata = 32'h12345678; end
      if (e == 60) we = 1'b0;
      if (ready === 1'b1) begin edges = e; break; end
    end
    checks++; if (edges !== 183) begin errors++; $display("FAIL write_mix_latency: got %0d edges want 183", edges); end
    read_all(0);
    for (int k = 0; k < T; k++) begin
      checks++;
      if (got_s[k] !== exp_s[k]) begin errors++; $display("FAIL write_mix_S%0d: got %h want %h", k, got_s[k], exp_s[k]); end
    end
    $display("test_s_write done");
  endtask
`endif

  initial begin
    rst = 1'b1; start = 1'b0; start5 = 1'b0;
    key = '0; key5 = 40'h0504030201;
    a1 = 0; a2 = 0; a1_5 = 0; a2_5 = 0;
`ifdef RC5_S_WRITE_EN
    we = 1'b0; waddr = 0; wdata = 0;
    we5 = 1'b0; waddr5 = 0; wdata5 = 0;
`endif
    #2 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_zero_key();
    test_restart_from_done();
    test_start_while_busy();
    test_reset_mid_run();
    test_short_key();
`ifdef RC5_S_WRITE_EN
    test_s_write();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
